// File: rtl/step_pattern_engine.sv
// Drum step sequencer core: NCH x NSTEP pattern, edit/play/raw modes.
// Optional SEQ_SWING_EN adds a swing input that lengthens even steps.
module step_pattern_engine #(
  parameter int NCH    = 4,
  parameter int NSTEP  = 8,
  parameter int TICK_W = 20,
  localparam int SW    = $clog2(NSTEP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              step_left,
  input  logic              step_right,
  input  logic [NCH-1:0]    tgl,
  input  logic [NCH-1:0]    raw,
  input  logic [TICK_W-1:0] beat_lim,
  input  logic [TICK_W-1:0] gate_len,
`ifdef SEQ_SWING_EN
  input  logic [TICK_W-1:0] swing,
`endif
  output logic [SW-1:0]     cursor,
  output logic [NSTEP-1:0]  step_oh,
  output logic [NCH-1:0]    cur_pat,
  output logic [NCH-1:0]    trig,
  output logic              beat
);

  typedef enum logic [1:0] {
    M_EDIT = 2'd0,
    M_PLAY = 2'd1,
    M_RAW  = 2'd2,
    M_IDLE = 2'd3
  } mode_e;

  localparam int TW = TICK_W + 1;
  localparam logic [SW-1:0] LAST = SW'(NSTEP - 1);

  logic [NCH-1:0]   pat_q [NSTEP];
  logic [NCH-1:0]   pat_d [NSTEP];
  logic [SW-1:0]    cursor_q, cursor_d;
  logic [TW-1:0]    tick_q, tick_d;
  mode_e            mode_q, mode_d;
  logic [NSTEP-1:0] step_oh_q, step_oh_d;
  logic [NCH-1:0]   cur_pat_q, cur_pat_d;
  logic [NCH-1:0]   trig_q, trig_d;
  logic             beat_q, beat_d;

  logic [SW-1:0]    nxt, prv;
  logic [TW-1:0]    lim;
  logic             gate_on;

  // Tick is one bit wider so a swung even step can exceed beat_lim.
`ifdef SEQ_SWING_EN
  logic [TICK_W-1:0] s;
  always_comb begin
    s   = (swing < beat_lim) ? swing : beat_lim;
    lim = cursor_q[0] ? ({1'b0, beat_lim} - {1'b0, s})
                      : ({1'b0, beat_lim} + {1'b0, s});
  end
`else
  assign lim = {1'b0, beat_lim};
`endif

  assign nxt = (cursor_q == LAST) ? '0 : cursor_q + SW'(1);
  assign prv = (cursor_q == '0) ? LAST : cursor_q - SW'(1);

  always_comb begin
    mode_d   = mode_e'(mode);
    pat_d    = pat_q;
    cursor_d = cursor_q;
    tick_d   = tick_q;
    beat_d   = 1'b0;
    trig_d   = '0;
    if (mode_d != mode_q) begin
      cursor_d = '0;
      tick_d   = '0;
      beat_d   = (mode_d == M_PLAY);
    end else begin
      unique case (mode_d)
        M_EDIT: begin
          pat_d[cursor_q] = pat_q[cursor_q] ^ tgl;
          if (step_right && !step_left)
            cursor_d = nxt;
          else if (step_left && !step_right)
            cursor_d = prv;
        end
        M_PLAY: begin
          if (tick_q >= lim) begin
            tick_d   = '0;
            cursor_d = nxt;
            beat_d   = 1'b1;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        M_RAW: begin
          cursor_d = '0;
          tick_d   = '0;
        end
        M_IDLE: begin
        end
      endcase
    end
    gate_on = (tick_d < {1'b0, gate_len});
    if (mode_d == M_PLAY)
      trig_d = (pat_d[cursor_d] & {NCH{gate_on}}) | raw;
    else if (mode_d == M_RAW)
      trig_d = raw;
    cur_pat_d = pat_d[cursor_d];
    step_oh_d = {{(NSTEP-1){1'b0}}, 1'b1} << cursor_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSTEP; i++)
        pat_q[i] <= '0;
      cursor_q  <= '0;
      tick_q    <= '0;
      mode_q    <= M_EDIT;
      step_oh_q <= {{(NSTEP-1){1'b0}}, 1'b1};
      cur_pat_q <= '0;
      trig_q    <= '0;
      beat_q    <= 1'b0;
    end else begin
      pat_q     <= pat_d;
      cursor_q  <= cursor_d;
      tick_q    <= tick_d;
      mode_q    <= mode_d;
      step_oh_q <= step_oh_d;
      cur_pat_q <= cur_pat_d;
      trig_q    <= trig_d;
      beat_q    <= beat_d;
    end
  end

  assign cursor  = cursor_q;
  assign step_oh = step_oh_q;
  assign cur_pat = cur_pat_q;
  assign trig    = trig_q;
  assign beat    = beat_q;

endmodule

// File: tb/tb_step_pattern_engine.sv
// Directed bench for step_pattern_engine (4 ch x 8 steps).
// Swing checks build only with SEQ_SWING_EN.
module tb_step_pattern_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        step_left, step_right;
  logic [3:0]  tgl, raw;
  logic [19:0] beat_lim, gate_len;
`ifdef SEQ_SWING_EN
  logic [19:0] swing;
`endif
  logic [2:0]  cursor;
  logic [7:0]  step_oh;
  logic [3:0]  cur_pat, trig;
  logic        beat;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  step_pattern_engine dut (
    .clk(clk), .rst(rst), .mode(mode),
    .step_left(step_left), .step_right(step_right),
    .tgl(tgl), .raw(raw),
    .beat_lim(beat_lim), .gate_len(gate_len),
`ifdef SEQ_SWING_EN
    .swing(swing),
`endif
    .cursor(cursor), .step_oh(step_oh),
    .cur_pat(cur_pat), .trig(trig), .beat(beat)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_r();
    step_right = 1'b1; tick(); step_right = 1'b0;
  endtask

  task automatic press_l();
    step_left = 1'b1; tick(); step_left = 1'b0;
  endtask

  task automatic toggle(input logic [3:0] v);
    tgl = v; tick(); tgl = '0;
  endtask

  task automatic wait_beat(output int len);
    len = 0;
    do begin
      tick();
      len++;
    end while (!beat && len < 200);
  endtask

  initial begin
    rst = 1'b1; mode = 2'd0;
    step_left = 0; step_right = 0;
    tgl = '0; raw = '0;
    beat_lim = 20'd9; gate_len = 20'd4;
`ifdef SEQ_SWING_EN
    swing = '0;
`endif
    tick(); tick();
    rst = 1'b0;
    chk("rst_cursor", 32'(cursor), 0);
    chk("rst_oh", 32'(step_oh), 32'h01);
    chk("rst_pat", 32'(cur_pat), 0);
    chk("rst_trig", 32'(trig), 0);
    chk("rst_beat", 32'(beat), 0);

    press_r(); press_r(); press_r();
    toggle(4'b1000);
    chk("ed_cursor", 32'(cursor), 3);
    chk("ed_pat", 32'(cur_pat), 32'h8);
    chk("ed_oh", 32'(step_oh), 32'h08);
    chk("ed_trig", 32'(trig), 0);

    press_l(); press_l(); press_l();
    toggle(4'b0001);
    chk("ed_pat0", 32'(cur_pat), 1);
    press_l();
    chk("wrap_left", 32'(cursor), 7);
    chk("wrap_oh", 32'(step_oh), 32'h80);
    step_left = 1; step_right = 1; tick();
    step_left = 0; step_right = 0;
    chk("both_hold", 32'(cursor), 7);

    mode = 2'd1; tick();
    chk("pl_beat0", 32'(beat), 1);
    chk("pl_cur0", 32'(cursor), 0);
    chk("pl_trig0", 32'(trig), 1);
    for (int k = 1; k < 10; k++) begin
      tick();
      chk("pl_gate", 32'(trig), (k < 4) ? 1 : 0);
      chk("pl_nobeat", 32'(beat), 0);
    end
    tick();
    chk("pl_beat1", 32'(beat), 1);
    chk("pl_cur1", 32'(cursor), 1);
    for (int s = 2; s <= 8; s++) begin
      repeat (10) tick();
      chk("pl_step", 32'(cursor), 32'(s % 8));
      chk("pl_stepbeat", 32'(beat), 1);
    end
    chk("pl_wrap_trig", 32'(trig), 1);

    repeat (10) tick();
    chk("pl_empty", 32'(trig), 0);
    raw = 4'b0100; tick();
    chk("pl_raw", 32'(trig), 32'h4);
    raw = '0;
    repeat (39) tick();
    chk("pl_cur5", 32'(cursor), 5);
    mode = 2'd0; tick();
    chk("sw_cursor", 32'(cursor), 0);
    chk("sw_trig", 32'(trig), 0);

    mode = 2'd2; raw = 4'b1111; tick();
    chk("raw_trig", 32'(trig), 32'hf);
    tick();
    chk("raw_trig2", 32'(trig), 32'hf);
    chk("raw_beat", 32'(beat), 0);
    chk("raw_cur", 32'(cursor), 0);

    mode = 2'd0; raw = '0;
    rst = 1'b1; tick(); rst = 1'b0;
    chk("clr_pat0", 32'(cur_pat), 0);
    press_r(); press_r(); press_r();
    chk("clr_pat3", 32'(cur_pat), 0);

    beat_lim = 20'd0;
    mode = 2'd1; tick();
    chk("bl0_beat", 32'(beat), 1);
    chk("bl0_cur", 32'(cursor), 0);
    tick();
    chk("bl0_beat2", 32'(beat), 1);
    chk("bl0_cur2", 32'(cursor), 1);
    tick();
    chk("bl0_cur3", 32'(cursor), 2);

`ifdef SEQ_SWING_EN
    beat_lim = 20'd9; swing = 20'd3;
    mode = 2'd3; tick();
    mode = 2'd1; tick();
    wait_beat(n);
    chk("swing_even", 32'(n), 13);
    wait_beat(n);
    chk("swing_odd", 32'(n), 7);
    swing = 20'd20;
    mode = 2'd3; tick();
    mode = 2'd1; tick();
    wait_beat(n);
    chk("swing_max_even", 32'(n), 19);
    wait_beat(n);
    chk("swing_max_odd", 32'(n), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
